gpi_debounce: RTL and testbench

Board-input conditioning stage between the raw switch pins and the demo system's general-purpose input port. Each bit passes through a two-flop synchroniser and a per-bit stability counter. The output changes only after the synchronised input has held a new level for DebounceCycles consecutive clk_sys_i cycles. Registered single-cycle rise, fall and change pulses are produced alongside the clean levels for software-visible edge capture.

---
 rtl/gpi_debounce_pkg.sv | 17 +
 rtl/gpi_debounce_bit.sv | 66 ++++++
 rtl/gpi_debounce.sv | 70 +++++++
 tb/tb_gpi_debounce.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpi_debounce_pkg.sv
// Shared types and helpers for the general-purpose input debouncer.
// Holds the per-bit edge classification and the counter sizing rule.
package gpi_debounce_pkg;

  // Outcome of one bit's update on a clock edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Counter width able to hold 0..cycles (the counter itself never passes cycles-1).
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One debounced input bit: stability counter, stable level and edge pulses.
// The next-state pulses are also exported so the top can register changed_o in the same cycle.
module gpi_debounce_bit
  import gpi_debounce_pkg::*;
#(
  parameter int DebounceCycles = 50000,
  parameter int CntWidth       = cnt_width(DebounceCycles)
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic sync_level,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic                stable_reg;
  logic                stable_next;
  logic [CntWidth-1:0] cnt_reg;
  logic [CntWidth-1:0] cnt_next;
  logic                rise_reg;
  logic                fall_reg;
  edge_e               edge_next;

  // Counter only runs while the synchronised input disagrees with the stable level,
  // so a glitch that returns early clears it and never reaches the output.
  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    edge_next   = EDGE_NONE;
    if (sync_level != stable_reg) begin
      if (cnt_reg == CntLast) begin
        stable_next = sync_level;
        edge_next   = sync_level ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_next = cnt_reg + CntWidth'(1);
      end
    end
  end

  assign rise_next = (edge_next == EDGE_RISE);
  assign fall_next = (edge_next == EDGE_FALL);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  assign level = stable_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/gpi_debounce.sv
// Board switch conditioning: two-flop synchroniser per pin, then a per-bit debouncer.
// Produces clean levels plus registered rise/fall/changed pulses for edge capture.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int Width          = 4,
  parameter int DebounceCycles = 50000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam int CntWidth = cnt_width(DebounceCycles);

  // Local synchroniser rather than the library primitive, which resets asynchronously.
  (* ASYNC_REG = "TRUE" *) logic [Width-1:0] sync1_reg;
  (* ASYNC_REG = "TRUE" *) logic [Width-1:0] sync2_reg;

  logic [Width-1:0] rise_next;
  logic [Width-1:0] fall_next;
  logic             changed_reg;
  logic             changed_next;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= gp_raw_i;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < Width; gi++) begin : g_bit
      gpi_debounce_bit #(
        .DebounceCycles(DebounceCycles),
        .CntWidth      (CntWidth)
      ) u_bit (
        .clk_sys_i (clk_sys_i),
        .rst_sys_ni(rst_sys_ni),
        .sync_level(sync2_reg[gi]),
        .level     (gp_o[gi]),
        .rise      (rise_o[gi]),
        .fall      (fall_o[gi]),
        .rise_next (rise_next[gi]),
        .fall_next (fall_next[gi])
      );
    end
  endgenerate

  // Built from next-state pulses so changed_o lands on the same edge as gp_o.
  assign changed_next = |(rise_next | fall_next);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= changed_next;
    end
  end

  assign changed_o = changed_reg;

endmodule

// File: tb/tb_gpi_debounce.sv
// Self-checking bench for gpi_debounce: directed scenarios plus random pins
// against a sliding-window reference model (DebounceCycles=4), and a DebounceCycles=1 build.
module tb_gpi_debounce;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw, raw1;
  logic [W-1:0] gp, rise, fall, gp1, rise1, fall1;
  logic         changed, changed1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_sync1, m_sync2, m_stable, m_rise, m_fall;
  logic         m_changed;
  logic [W-1:0] hist[$];

  always #5 clk = ~clk;

  gpi_debounce #(.Width(W), .DebounceCycles(D)) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .gp_raw_i  (raw),
    .gp_o      (gp),
    .rise_o    (rise),
    .fall_o    (fall),
    .changed_o (changed)
  );

  gpi_debounce #(.Width(W), .DebounceCycles(1)) dut1 (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .gp_raw_i  (raw1),
    .gp_o      (gp1),
    .rise_o    (rise1),
    .fall_o    (fall1),
    .changed_o (changed1)
  );

  // Drive one clock edge and advance the model: a bit flips once the last D
  // samples it saw (since reset) all differ from its current clean level.
  task automatic tick(input logic [W-1:0] r, input logic rn, input logic [W-1:0] r1 = '0);
    logic [W-1:0] seen;
    logic         all_diff;
    raw   = r;
    rst_n = rn;
    raw1  = r1;
    @(posedge clk);
    m_rise = '0;
    m_fall = '0;
    if (!rn) begin
      m_sync1  = '0;
      m_sync2  = '0;
      m_stable = '0;
      hist.delete();
    end else begin
      seen    = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = r;
      hist.push_back(seen);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int i = 0; i < D; i++)
            if (hist[i][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) begin
            if (m_stable[b]) m_fall[b] = 1'b1;
            else             m_rise[b] = 1'b1;
            m_stable[b] = ~m_stable[b];
          end
        end
      end
    end
    m_changed = |(m_rise | m_fall);
    #1;
  endtask

  task automatic settle(input logic [W-1:0] r, input int n);
    for (int i = 0; i < n; i++) tick(r, 1'b1);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick('0, 1'b0);
      n_checks++;
      if ({gp, rise, fall, changed} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d gp=%b rise=%b fall=%b chg=%b, want all 0", i, gp, rise, fall, changed);
      end
      n_checks++;
      if ({gp1, rise1, fall1, changed1} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold_d1 cyc=%0d gp=%b rise=%b fall=%b chg=%b, want all 0", i, gp1, rise1, fall1, changed1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick('0, 1'b1);
      n_checks++;
      if ({gp, rise, fall, changed} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d gp=%b rise=%b fall=%b chg=%b, want all 0", i, gp, rise, fall, changed);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_rise;
    logic [W-1:0] exp_gp, exp_rise;
    settle('0, 8);
    tick(4'b0001, 1'b1);  // edge k
    for (int j = 1; j <= 7; j++) begin
      tick(4'b0001, 1'b1);
      exp_gp   = (j >= 5) ? 4'b0001 : 4'b0000;
      exp_rise = (j == 5) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (gp !== exp_gp || rise !== exp_rise || fall !== 4'b0000 || changed !== (j == 5)) begin
        n_fail++;
        $display("FAIL single_rise k+%0d gp=%b rise=%b fall=%b chg=%b, want gp=%b rise=%b fall=0000 chg=%0d",
                 j, gp, rise, fall, changed, exp_gp, exp_rise, (j == 5));
      end
    end
    $display("test_single_rise done");
  endtask

  task automatic test_glitch;
    logic [W-1:0] base;
    int           rises, falls, others;
    base = 4'b0001;
    for (int len = 3; len <= 4; len++) begin
      settle(base, 10);
      rises = 0; falls = 0; others = 0;
      for (int i = 0; i < len + 14; i++) begin
        tick((i < len) ? (base | 4'b0010) : base, 1'b1);
        if (rise[1]) rises++;
        if (fall[1]) falls++;
        if ((rise & 4'b1101) != 0 || (fall & 4'b1101) != 0) others++;
      end
      n_checks++;
      if (rises != len - 3 || falls != len - 3 || others != 0) begin
        n_fail++;
        $display("FAIL glitch len=%0d rises=%0d falls=%0d other_pulses=%0d, want rises=%0d falls=%0d other=0",
                 len, rises, falls, others, len - 3, len - 3);
      end
      $display("test_glitch len=%0d rises=%0d falls=%0d", len, rises, falls);
    end
  endtask

  task automatic test_simul_fall;
    int           fall_cycles, chg_cycles;
    logic [W-1:0] fall_val;
    settle(4'b0101, 12);
    n_checks++;
    if (gp !== 4'b0101) begin
      n_fail++;
      $display("FAIL simul_fall_settle gp=%b, want 0101", gp);
    end
    fall_cycles = 0; chg_cycles = 0; fall_val = '0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000, 1'b1);
      if (fall != 0) begin fall_cycles++; fall_val = fall; end
      if (changed) chg_cycles++;
    end
    n_checks++;
    if (fall_cycles != 1 || fall_val !== 4'b0101 || chg_cycles != 1 || gp !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_fall fall_cycles=%0d fall=%b chg_cycles=%0d gp=%b, want 1 0101 1 0000",
               fall_cycles, fall_val, chg_cycles, gp);
    end
    $display("test_simul_fall done");
  endtask

  task automatic test_reset_midcount;
    logic [W-1:0] exp_gp, exp_rise;
    settle('0, 10);
    for (int i = 0; i < 4; i++) tick(4'b1000, 1'b1);  // count at 2 after these
    tick(4'b1000, 1'b0);
    n_checks++;
    if ({gp, rise, fall, changed} !== '0) begin
      n_fail++;
      $display("FAIL reset_midcount gp=%b rise=%b fall=%b chg=%b, want all 0", gp, rise, fall, changed);
    end
    for (int j = 1; j <= 8; j++) begin
      tick(4'b1000, 1'b1);  // j==1 is the first post-reset sample
      exp_gp   = (j >= 6) ? 4'b1000 : 4'b0000;
      exp_rise = (j == 6) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (gp !== exp_gp || rise !== exp_rise || changed !== (j == 6)) begin
        n_fail++;
        $display("FAIL reset_release edge=%0d gp=%b rise=%b chg=%b, want gp=%b rise=%b chg=%0d",
                 j, gp, rise, changed, exp_gp, exp_rise, (j == 6));
      end
    end
    $display("test_reset_midcount done");
  endtask

  task automatic test_d1;
    logic [W-1:0] exp_gp, exp_rise, exp_fall;
    settle('0, 6);
    tick('0, 1'b1, 4'b0001);  // edge k, one-cycle raw pulse
    for (int j = 1; j <= 5; j++) begin
      tick('0, 1'b1, 4'b0000);
      exp_gp   = (j == 2) ? 4'b0001 : 4'b0000;
      exp_rise = (j == 2) ? 4'b0001 : 4'b0000;
      exp_fall = (j == 3) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (gp1 !== exp_gp || rise1 !== exp_rise || fall1 !== exp_fall || changed1 !== (j == 2 || j == 3)) begin
        n_fail++;
        $display("FAIL d1_glitch k+%0d gp=%b rise=%b fall=%b chg=%b, want gp=%b rise=%b fall=%b",
                 j, gp1, rise1, fall1, changed1, exp_gp, exp_rise, exp_fall);
      end
    end
    $display("test_d1 done");
  endtask

  task automatic test_random;
    logic [W-1:0] lvl;
    int           hold, errs;
    errs = 0;
    for (int s = 0; s < 60; s++) begin
      lvl  = W'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        tick(lvl, 1'b1);
        n_checks++;
        if (gp !== m_stable || rise !== m_rise || fall !== m_fall || changed !== m_changed) begin
          n_fail++;
          errs++;
          if (errs < 10)
            $display("FAIL random seg=%0d gp=%b rise=%b fall=%b chg=%b, want gp=%b rise=%b fall=%b chg=%b",
                     s, gp, rise, fall, changed, m_stable, m_rise, m_fall, m_changed);
        end
      end
    end
    $display("test_random done errors=%0d", errs);
  endtask

  initial begin
    raw = '0; raw1 = '0; rst_n = 1'b0;
    m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_simul_fall();
    test_reset_midcount();
    test_d1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
